// File: rtl/system_server_cpu_mult_pipe_pkg.sv
// Shared constants for the server CPU multiplier: pipeline depth and the
// sign-mode encoding the decoder uses to drive the per-operand signed flags.
package system_server_cpu_mult_pkg;

  localparam int MULT_PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    MODE_UU = 2'd0,
    MODE_SU = 2'd1,
    MODE_SS = 2'd2
  } mult_mode_e;

  // Returns {src1_signed, src2_signed}.
  function automatic logic [1:0] mode_signs(mult_mode_e m);
    case (m)
      MODE_SU: return 2'b10;
      MODE_SS: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/system_server_cpu_mult_pipe_if.sv
// Operand/result bundle between the execute stage (master) and the multiplier (slave).
interface system_server_cpu_mult_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             src1_signed;
  logic             src2_signed;
  logic             out_valid;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             busy;

  modport master (
    output en, flush, in_valid, src1, src2, src1_signed, src2_signed,
    input  out_valid, out_lo, out_hi, busy
  );

  modport slave (
    input  en, flush, in_valid, src1, src2, src1_signed, src2_signed,
    output out_valid, out_lo, out_hi, busy
  );
endinterface

// File: rtl/system_server_cpu_mult_pipe_partial.sv
// HALF x HALF unsigned multiplier with an enabled output register; one DSP slice.
module system_server_cpu_mult_partial #(
  parameter int HALF = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  p <= '0;
    else if (en)   p <= {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
  end

endmodule

// File: rtl/system_server_cpu_mult_pipe.sv
// Two-stage full-width multiplier: registered half-width partial products, then
// assembly with a sign correction term so one datapath serves all sign modes.
module system_server_cpu_mult_pipe
  import system_server_cpu_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                          clk,
  input logic                          reset_n,
  system_server_cpu_mult_pipe_if.slave bus
);

  localparam int HALF  = WIDTH / 2;
  localparam int DEPTH = MULT_PIPE_DEPTH;

  // Partial product index: 0=ll, 1=lh, 2=hl, 3=hh (bit1 picks src1 half, bit0 src2 half).
  logic [3:0][HALF-1:0]  opa, opb;
  logic [3:0][WIDTH-1:0] pp;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opa[i] = i[1] ? bus.src1[WIDTH-1:HALF] : bus.src1[HALF-1:0];
      opb[i] = i[0] ? bus.src2[WIDTH-1:HALF] : bus.src2[HALF-1:0];
    end
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_pp
    system_server_cpu_mult_partial #(.HALF(HALF)) u_pp (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (bus.en),
      .a       (opa[g]),
      .b       (opb[g]),
      .p       (pp[g])
    );
  end

  // A negative operand's two's-complement weight is -2^W, which subtracts the
  // other raw operand from the upper half of the unsigned product.
  logic [WIDTH-1:0] corr_d, corr_q;
  always_comb begin
    corr_d = ((bus.src1_signed && bus.src1[WIDTH-1]) ? bus.src2 : '0)
           + ((bus.src2_signed && bus.src2[WIDTH-1]) ? bus.src1 : '0);
  end

  logic [WIDTH:0]       mid;
  logic [2*WIDTH-1:0]   sum, prod_q;
  always_comb begin
    mid = {1'b0, pp[1]} + {1'b0, pp[2]};
    sum = {pp[3], {WIDTH{1'b0}}}
        + ({{(WIDTH-1){1'b0}}, mid} << HALF)
        + {{WIDTH{1'b0}}, pp[0]}
        - {corr_q, {WIDTH{1'b0}}};
  end

  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      corr_q   <= '0;
      prod_q   <= '0;
    end else begin
      if (bus.flush)   vld_pipe <= '0;
      else if (bus.en) vld_pipe <= {vld_pipe[DEPTH-1:1], bus.in_valid};
      if (bus.en) begin
        corr_q <= corr_d;
        prod_q <= sum;
      end
    end
  end

  assign bus.out_lo    = prod_q[WIDTH-1:0];
  assign bus.out_hi    = prod_q[2*WIDTH-1:WIDTH];
  assign bus.out_valid = vld_pipe[DEPTH];
  assign bus.busy      = |vld_pipe;

endmodule

// File: tb/tb_system_server_cpu_mult_pipe.sv
// Scoreboard bench: directed cases on a 32-bit instance, random sweeps on 8/16-bit instances.
module tb_system_server_cpu_mult_pipe;
  import system_server_cpu_mult_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  logic [63:0] q32[$];
  logic [63:0] q16[$];
  logic [63:0] q8[$];

  system_server_cpu_mult_pipe_if #(.WIDTH(32)) b32 ();
  system_server_cpu_mult_pipe_if #(.WIDTH(16)) b16 ();
  system_server_cpu_mult_pipe_if #(.WIDTH(8))  b8  ();

  system_server_cpu_mult_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
  system_server_cpu_mult_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16.slave));
  system_server_cpu_mult_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input int w);
    logic [63:0] m, ax, bx, p;
    m  = (64'd1 << w) - 64'd1;
    ax = {32'd0, a} & m;
    bx = {32'd0, b} & m;
    if (sa && ax[w-1]) ax = ax | ~m;
    if (sb && bx[w-1]) bx = bx | ~m;
    p = ax * bx;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    b32.en = 1'b1; b32.flush = 1'b0; b32.in_valid = 1'b0;
    step();
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                         input bit push, input logic [63:0] exp);
    b32.en = 1'b1; b32.flush = 1'b0; b32.in_valid = 1'b1;
    b32.src1 = a; b32.src2 = b;
    b32.src1_signed = s[1]; b32.src2_signed = s[0];
    if (push) q32.push_back(exp);
    step();
    b32.in_valid = 1'b0;
  endtask

  // Consumer: a result is taken on an enabled edge while out_valid is high.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n) begin
      if (b32.out_valid && b32.en) begin
        if (q32.size() == 0) chk("sb32_extra", 64'(q32.size()), 64'd1);
        else begin e = q32.pop_front(); chk("res32", {b32.out_hi, b32.out_lo}, e); end
      end
      if (b16.out_valid && b16.en) begin
        if (q16.size() == 0) chk("sb16_extra", 64'(q16.size()), 64'd1);
        else begin e = q16.pop_front(); chk("res16", {32'd0, b16.out_hi, b16.out_lo}, e); end
      end
      if (b8.out_valid && b8.en) begin
        if (q8.size() == 0) chk("sb8_extra", 64'(q8.size()), 64'd1);
        else begin e = q8.pop_front(); chk("res8", {48'd0, b8.out_hi, b8.out_lo}, e); end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n16, n8;
    logic e;
    logic [1:0] s;
    b32.en = 1'b0; b32.flush = 1'b0; b32.in_valid = 1'b0;
    b32.src1 = '0; b32.src2 = '0; b32.src1_signed = 1'b0; b32.src2_signed = 1'b0;
    b16.en = 1'b0; b16.flush = 1'b0; b16.in_valid = 1'b0;
    b16.src1 = '0; b16.src2 = '0; b16.src1_signed = 1'b0; b16.src2_signed = 1'b0;
    b8.en = 1'b0; b8.flush = 1'b0; b8.in_valid = 1'b0;
    b8.src1 = '0; b8.src2 = '0; b8.src1_signed = 1'b0; b8.src2_signed = 1'b0;

    step(); step();
    chk("rst_lo", 64'(b32.out_lo), 64'd0);
    chk("rst_hi", 64'(b32.out_hi), 64'd0);
    chk("rst_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_busy", 64'(b32.busy), 64'd0);
    reset_n = 1'b1;
    step();

    // Unsigned all-ones, latency and one-cycle pulse.
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, mode_signs(MODE_UU), 1, 64'hFFFF_FFFE_0000_0001);
    chk("lat_busy", 64'(b32.busy), 64'd1);
    chk("lat_v0", 64'(b32.out_valid), 64'd0);
    idle32();
    chk("lat_v1", 64'(b32.out_valid), 64'd1);
    chk("uu_hi", 64'(b32.out_hi), 64'hFFFF_FFFE);
    idle32();
    chk("pulse_v", 64'(b32.out_valid), 64'd0);

    // Sign modes back-to-back.
    issue32(32'h8000_0000, 32'h8000_0000, mode_signs(MODE_SS), 1, 64'h4000_0000_0000_0000);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, mode_signs(MODE_SS), 1, 64'h0000_0000_0000_0001);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, mode_signs(MODE_SU), 1, 64'hFFFF_FFFF_0000_0001);
    issue32(32'd5, 32'hFFFF_FFFD, 2'b01, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    issue32(32'h7FFF_FFFF, 32'h8000_0000, mode_signs(MODE_SS), 1, 64'hC000_0000_8000_0000);
    repeat (3) idle32();
    chk("bt_busy", 64'(b32.busy), 64'd0);

    // Throughput with a 3-cycle stall after the first result.
    issue32(32'd2, 32'd3, mode_signs(MODE_UU), 1, 64'd6);
    issue32(32'd4, 32'd5, mode_signs(MODE_UU), 1, 64'd20);
    chk("tp_first", 64'(b32.out_lo), 64'd6);
    b32.en = 1'b0; b32.in_valid = 1'b1; b32.src1 = 32'd6; b32.src2 = 32'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_lo", 64'(b32.out_lo), 64'd6);
      chk("stall_vld", 64'(b32.out_valid), 64'd1);
    end
    chk("stall_busy", 64'(b32.busy), 64'd1);
    issue32(32'd6, 32'd7, mode_signs(MODE_UU), 1, 64'd42);
    chk("tp_second", 64'(b32.out_lo), 64'd20);
    idle32();
    chk("tp_third", 64'(b32.out_lo), 64'd42);
    idle32();
    chk("tp_drain", 64'(b32.out_valid), 64'd0);

    // Flush cancels the operation in stage 1.
    issue32(32'd2, 32'd3, mode_signs(MODE_UU), 0, 64'd0);
    b32.flush = 1'b1; b32.en = 1'b1; b32.in_valid = 1'b0;
    step();
    b32.flush = 1'b0;
    chk("fl_busy", 64'(b32.busy), 64'd0);
    for (int i = 0; i < 2; i++) begin
      chk("fl_vld", 64'(b32.out_valid), 64'd0);
      idle32();
    end

    // Flush while stalled: valid drops, data holds.
    issue32(32'd8, 32'd9, mode_signs(MODE_UU), 0, 64'd0);
    idle32();
    b32.en = 1'b0; b32.flush = 1'b1;
    step();
    chk("fs_vld", 64'(b32.out_valid), 64'd0);
    chk("fs_lo", 64'(b32.out_lo), 64'd72);
    chk("fs_busy", 64'(b32.busy), 64'd0);
    b32.flush = 1'b0;
    idle32();

    // Asynchronous reset mid-pipeline.
    issue32(32'd11, 32'd13, mode_signs(MODE_UU), 0, 64'd0);
    issue32(32'd3, 32'd3, mode_signs(MODE_UU), 0, 64'd0);
    chk("mid_pre_vld", 64'(b32.out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_lo", 64'(b32.out_lo), 64'd0);
    chk("mid_hi", 64'(b32.out_hi), 64'd0);
    chk("mid_vld", 64'(b32.out_valid), 64'd0);
    chk("mid_busy", 64'(b32.busy), 64'd0);
    b32.en = 1'b1; b32.in_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("mid_post_vld", 64'(b32.out_valid), 64'd0);

    // Random sweep on the narrow instances with random stalls.
    n16 = 0; n8 = 0;
    for (int cyc = 0; cyc < 5000 && (n16 < 500 || n8 < 500); cyc++) begin
      e = ($urandom_range(0, 7) != 0);
      b16.en = e; b8.en = e;
      b16.in_valid = (n16 < 500) && ($urandom_range(0, 3) != 0);
      b16.src1 = 16'($urandom); b16.src2 = 16'($urandom);
      s = 2'($urandom_range(0, 3));
      b16.src1_signed = s[1]; b16.src2_signed = s[0];
      if (e && b16.in_valid) begin
        q16.push_back(ref_mul({16'd0, b16.src1}, {16'd0, b16.src2}, s[1], s[0], 16));
        n16++;
      end
      b8.in_valid = (n8 < 500) && ($urandom_range(0, 3) != 0);
      b8.src1 = 8'($urandom); b8.src2 = 8'($urandom);
      s = 2'($urandom_range(0, 3));
      b8.src1_signed = s[1]; b8.src2_signed = s[0];
      if (e && b8.in_valid) begin
        q8.push_back(ref_mul({24'd0, b8.src1}, {24'd0, b8.src2}, s[1], s[0], 8));
        n8++;
      end
      step();
    end
    b16.en = 1'b1; b16.in_valid = 1'b0;
    b8.en = 1'b1; b8.in_valid = 1'b0;
    repeat (6) step();

    chk("n16_issued", 64'(n16), 64'd500);
    chk("n8_issued", 64'(n8), 64'd500);
    chk("sb32_left", 64'(q32.size()), 64'd0);
    chk("sb16_left", 64'(q16.size()), 64'd0);
    chk("sb8_left", 64'(q8.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
